// File: rtl/n_term_probe_pkg.sv
// Shared constants, state encoding and loopback mapping for the single2 north-edge probe tile.
package n_term_probe_pkg;
  localparam int PROBE_W = 52;
  localparam int CNT_W   = 6;

  localparam int N1_LO  = 0;
  localparam int N2M_LO = 4;
  localparam int N2E_LO = 12;
  localparam int N4_LO  = 20;
  localparam int NN4_LO = 36;

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} probe_state_e;

  // Bit order is reversed inside each wire group, never across groups.
  function automatic logic [PROBE_W-1:0] loopback(input logic [PROBE_W-1:0] raw);
    logic [PROBE_W-1:0] o;
    o = '0;
    for (int i = 0; i < 4; i++)  o[N1_LO+i]  = raw[N1_LO+3-i];
    for (int i = 0; i < 8; i++)  o[N2M_LO+i] = raw[N2M_LO+7-i];
    for (int i = 0; i < 8; i++)  o[N2E_LO+i] = raw[N2E_LO+7-i];
    for (int i = 0; i < 16; i++) o[N4_LO+i]  = raw[N4_LO+15-i];
    for (int i = 0; i < 16; i++) o[NN4_LO+i] = raw[NN4_LO+15-i];
    return o;
  endfunction
endpackage

// File: rtl/n_term_single2_probe_scan_ctrl.sv
// Probe scan controller: capture/shift FSM, shift counter, scan register and override image.
module probe_scan_ctrl
  import n_term_probe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_start,
  input  logic               shift_en,
  input  logic               scan_in,
  input  logic               inj_apply,
  input  logic               inj_clear,
  input  logic [PROBE_W-1:0] cap_data,
  output logic               scan_out,
  output logic               busy,
  output logic               done,
  output logic               ovr_active,
  output logic [PROBE_W-1:0] ovr
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PROBE_W - 1);

  probe_state_e       state, state_nxt;
  logic [PROBE_W-1:0] sr, sr_nxt, ovr_nxt, sh;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               act_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      ovr        <= '0;
      cnt        <= '0;
      ovr_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      ovr        <= ovr_nxt;
      cnt        <= cnt_nxt;
      ovr_active <= act_nxt;
    end
  end

  assign sh = {scan_in, sr[PROBE_W-1:1]};

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    ovr_nxt   = ovr;
    cnt_nxt   = cnt;
    act_nxt   = ovr_active;
    case (state)
      IDLE: begin
        // Idle shifting lets an override image be loaded without a capture.
        if (shift_en) sr_nxt = sh;
        if (cap_start) state_nxt = CAPTURE;
        else if (inj_apply) begin
          ovr_nxt = sr;
          act_nxt = 1'b1;
        end
      end
      CAPTURE: begin
        sr_nxt    = cap_data;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (shift_en) begin
          sr_nxt = sh;
          if (cnt == CNT_LAST) state_nxt = DONE;
          else                 cnt_nxt   = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (inj_clear) act_nxt = 1'b0;
  end

  assign scan_out = sr[0];
  assign busy     = (state == CAPTURE) || (state == SHIFT);
  assign done     = (state == DONE);
endmodule

// File: rtl/n_term_single2_probe.sv
// North-edge termination for single2: loops north wire groups back south, with scan probe and override.
module n_term_single2_probe
  import n_term_probe_pkg::*;
#(
  parameter int PIPE = 1
) (
  input  logic        UserCLK,
  input  logic        rst,
  input  logic [3:0]  N1END,
  input  logic [7:0]  N2MID,
  input  logic [7:0]  N2END,
  input  logic [15:0] N4END,
  input  logic [15:0] NN4END,
  output logic [3:0]  S1BEG,
  output logic [7:0]  S2BEG,
  output logic [7:0]  S2BEGb,
  output logic [15:0] S4BEG,
  output logic [15:0] SS4BEG,
  input  logic        cap_start,
  input  logic        shift_en,
  input  logic        scan_in,
  output logic        scan_out,
  input  logic        inj_apply,
  input  logic        inj_clear,
  output logic        busy,
  output logic        done,
  output logic        ovr_active
);
  logic [PROBE_W-1:0] raw, ovr, out_d, out_q;

  assign raw = {NN4END, N4END, N2END, N2MID, N1END};

  probe_scan_ctrl u_ctrl (
    .clk       (UserCLK),
    .rst       (rst),
    .cap_start (cap_start),
    .shift_en  (shift_en),
    .scan_in   (scan_in),
    .inj_apply (inj_apply),
    .inj_clear (inj_clear),
    .cap_data  (raw),
    .scan_out  (scan_out),
    .busy      (busy),
    .done      (done),
    .ovr_active(ovr_active),
    .ovr       (ovr)
  );

  // Override slices drive outputs as-is; only the loopback path reverses.
  assign out_d = ovr_active ? ovr : loopback(raw);

  generate
    if (PIPE != 0) begin : g_pipe
      always_ff @(posedge UserCLK or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
      end
    end else begin : g_comb
      assign out_q = out_d;
    end
  endgenerate

  assign S1BEG  = out_q[N1_LO  +: 4];
  assign S2BEG  = out_q[N2M_LO +: 8];
  assign S2BEGb = out_q[N2E_LO +: 8];
  assign S4BEG  = out_q[N4_LO  +: 16];
  assign SS4BEG = out_q[NN4_LO +: 16];
endmodule

// File: tb/tb_n_term_single2_probe.sv
// Scoreboard bench for n_term_single2_probe: directed test-plan sequences plus randomized traffic.
module tb_n_term_single2_probe;
  logic        UserCLK = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  N1END = '0;
  logic [7:0]  N2MID = '0, N2END = '0;
  logic [15:0] N4END = '0, NN4END = '0;
  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG, S2BEGb;
  logic [15:0] S4BEG, SS4BEG;
  logic        cap_start = 0, shift_en = 0, scan_in = 0, inj_apply = 0, inj_clear = 0;
  logic        scan_out, busy, done, ovr_active;

  n_term_single2_probe #(.PIPE(1)) dut (
    .UserCLK(UserCLK), .rst(rst),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .NN4END(NN4END),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG), .SS4BEG(SS4BEG),
    .cap_start(cap_start), .shift_en(shift_en), .scan_in(scan_in), .scan_out(scan_out),
    .inj_apply(inj_apply), .inj_clear(inj_clear),
    .busy(busy), .done(done), .ovr_active(ovr_active)
  );

  always #5 UserCLK = ~UserCLK;

  int n_cmp = 0, n_bad = 0, n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  localparam int GLO [5] = '{0, 4, 12, 20, 36};
  localparam int GW  [5] = '{4, 8, 8, 16, 16};

  function automatic logic [51:0] ref_out(input logic [51:0] r, input bit act, input logic [51:0] img);
    logic [51:0] o;
    if (act) return img;
    o = '0;
    for (int g = 0; g < 5; g++)
      for (int i = 0; i < GW[g]; i++) o[GLO[g]+i] = r[GLO[g]+GW[g]-1-i];
    return o;
  endfunction

  function automatic logic [51:0] raw_now();
    return {NN4END, N4END, N2END, N2MID, N1END};
  endfunction

  // Reference model: mode 0 idle, 1 capture, 2 shifting, 3 done.
  int          m_mode = 0, m_nshift = 0;
  logic [51:0] m_sr = '0, m_ovr = '0;
  bit          m_act = 0;
  logic [51:0] out_q[$];
  logic [51:0] stream_q[$];

  always @(posedge UserCLK or posedge rst) begin
    logic [51:0] r, old_sr;
    if (rst) begin
      m_mode = 0; m_nshift = 0; m_sr = '0; m_ovr = '0; m_act = 0;
      stream_q.delete();
      out_q.delete();
      out_q.push_back('0);
    end else begin
      r = raw_now();
      old_sr = m_sr;
      out_q.push_back(ref_out(r, m_act, m_ovr));
      case (m_mode)
        0: begin
          if (shift_en) m_sr = {scan_in, m_sr[51:1]};
          if (cap_start) m_mode = 1;
          else if (inj_apply) begin m_ovr = old_sr; m_act = 1; end
        end
        1: begin m_sr = r; m_nshift = 0; m_mode = 2; stream_q.push_back(r); end
        2: if (shift_en) begin
          m_sr = {scan_in, m_sr[51:1]};
          m_nshift++;
          if (m_nshift == 52) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
      if (inj_clear) m_act = 0;
    end
  end

  // Monitor: output compares each cycle; scan stream collected from the DUT and scored on done.
  logic [51:0] coll = '0, last_stream = '0;
  int          ncoll = 0;
  bit          busy_prev = 0;

  always @(negedge UserCLK) begin
    logic [51:0] e;
    if (rst) begin
      check("rst_outputs", {SS4BEG, S4BEG, S2BEGb, S2BEG, S1BEG}, '0);
      check("rst_flags", {busy, done, ovr_active, scan_out}, '0);
      out_q.delete();
      busy_prev = 0;
      ncoll = 0;
    end else begin
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        check("s_outputs", {SS4BEG, S4BEG, S2BEGb, S2BEG, S1BEG}, e);
      end
      check("busy", busy, (m_mode == 1 || m_mode == 2));
      check("done", done, (m_mode == 3));
      check("ovr_active", ovr_active, m_act);
      if (busy && !busy_prev) begin coll = '0; ncoll = 0; end
      else if (busy && busy_prev && shift_en) begin
        if (ncoll < 52) coll[ncoll] = scan_out;
        ncoll++;
      end
      if (done) begin
        n_done++;
        last_stream = coll;
        if (stream_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending capture at %0t", $time);
        end else begin
          e = stream_q.pop_front();
          check("scan_stream", coll, e);
          check("shift_count", ncoll, 52);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge UserCLK); #1; end
  endtask

  task automatic rand_data();
    N1END = 4'($urandom); N2MID = 8'($urandom); N2END = 8'($urandom);
    N4END = 16'($urandom); NN4END = 16'($urandom);
  endtask

  initial begin
    int d0;
    step(3);
    rst = 0;

    // Loopback reversal, one-cycle latency
    N1END = 4'b0001; NN4END = 16'h8000;
    step(1);
    check("t1_s1beg", S1BEG, 4'b1000);
    check("t1_ss4beg", SS4BEG, 16'h0001);

    // Capture of a held pattern and full 52-bit shift
    N1END = '0; NN4END = '0; N4END = 16'hA5C3;
    d0 = n_done;
    cap_start = 1; step(1);
    cap_start = 0; shift_en = 1; step(53);
    shift_en = 0; step(1);
    check("t2_done_once", n_done, d0 + 1);
    check("t2_stream_n4", last_stream[35:20], 16'hA5C3);

    // Load override image by idle shifting, then apply and clear
    for (int k = 0; k < 52; k++) begin
      scan_in = (k == 4); shift_en = 1; step(1);
    end
    shift_en = 0; scan_in = 0;
    inj_apply = 1; rand_data(); step(1);
    inj_apply = 0; rand_data(); step(1);
    check("t3_ovr_active", ovr_active, 1'b1);
    check("t3_s2beg", S2BEG, 8'h01);
    check("t3_others", {SS4BEG, S4BEG, S2BEGb, S1BEG}, '0);
    rand_data(); step(1);
    check("t3_s2beg_hold", S2BEG, 8'h01);
    inj_clear = 1; step(1);
    inj_clear = 0;
    check("t3_cleared", ovr_active, 1'b0);
    step(1);

    // cap_start wins over inj_apply; cap_start ignored mid-shift; shift_en gap at cnt=20
    d0 = n_done;
    cap_start = 1; inj_apply = 1; step(1);
    cap_start = 0; inj_apply = 0;
    check("t4_apply_dropped", ovr_active, 1'b0);
    shift_en = 1; step(1);
    step(10);
    cap_start = 1; inj_apply = 1; step(1);
    cap_start = 0; inj_apply = 0; step(9);
    shift_en = 0; rand_data(); step(10);
    shift_en = 1; step(32);
    shift_en = 0; step(1);
    check("t4_done_after_gap", n_done, d0 + 1);

    // Reset mid-shift aborts with no done
    rand_data(); d0 = n_done;
    cap_start = 1; step(1);
    cap_start = 0; shift_en = 1; step(31);
    rst = 1; #1;
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_scan_out", scan_out, 1'b0);
    step(2);
    shift_en = 0; rst = 0; step(60);
    check("t5_no_done", n_done, d0);
    rand_data();
    cap_start = 1; step(1);
    cap_start = 0; shift_en = 1; step(53);
    shift_en = 0; step(1);
    check("t5_recapture_done", n_done, d0 + 1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rand_data();
      scan_in   = 1'($urandom);
      cap_start = ($urandom_range(0, 24) == 0);
      shift_en  = ($urandom_range(0, 3) != 0);
      inj_apply = ($urandom_range(0, 11) == 0);
      inj_clear = ($urandom_range(0, 29) == 0);
      step(1);
    end
    cap_start = 0; inj_apply = 0; inj_clear = 0; shift_en = 1;
    step(80);
    shift_en = 0; step(2);
    check("pending_captures", stream_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/n_term_single2_probe.md
Name:
n_term_single2_probe

Overview:
- North-edge termination tile for the single2 fabric variant.
- Turns every north-travelling wire group back south, so wires reaching the top edge re-enter the fabric.
- Adds an observe/override probe: a 52-bit snapshot of all terminating wires, shifted out serially, plus a serially loaded override image that can replace the loopback for routing test.
- Sits at the top row of the fabric, one instance per column.

Parameters:
- PIPE, 1, 1 = loopback and override outputs pass through one register stage; 0 = combinational loopback path.
- PROBE_W, 52, snapshot/override width. Fixed by the wire count; localparam in the package, not overridable.

Ports:
- UserCLK  in  1  fabric user clock.
- rst  in  1  reset, asynchronous, active-high.
- N1END  in  4  single-hop wires arriving from south.
- N2MID  in  8  double-hop mid taps.
- N2END  in  8  double-hop ends.
- N4END  in  16  quad-hop ends.
- NN4END  in  16  long quad ends.
- S1BEG  out  4  single-hop wires sent back south.
- S2BEG  out  8  double-hop begin.
- S2BEGb  out  8  double-hop second begin.
- S4BEG  out  16  quad begin.
- SS4BEG  out  16  long quad begin.
- cap_start  in  1  one-cycle pulse requesting a snapshot.
- shift_en  in  1  advances the scan shift register one bit.
- scan_in  in  1  serial data shifted into the register MSB.
- scan_out  out  1  serial data out, equal to sr[0].
- inj_apply  in  1  pulse: load the shift register into the override image and enable override.
- inj_clear  in  1  pulse: disable override.
- busy  out  1  high in CAPTURE and SHIFT.
- done  out  1  one-cycle pulse when the shift completes.
- ovr_active  out  1  override currently driving the outputs.

Behaviour:
- Loopback mapping, index reversed within each group:
  - S1BEG[i] = N1END[3-i]; S2BEG[i] = N2MID[7-i]; S2BEGb[i] = N2END[7-i].
  - S4BEG[i] = N4END[15-i]; SS4BEG[i] = NN4END[15-i].
- Packing, shared by snapshot and override:
  - [3:0] N1/S1; [11:4] N2MID/S2BEG; [19:12] N2END/S2BEGb; [35:20] N4/S4; [51:36] NN4/SS4.
- Override: when ovr_active=1, each output group = its ovr slice taken directly, with no reversal.
- PIPE=1: outputs update on the UserCLK edge after their source changes (latency 1). PIPE=0: latency 0; override still sources from the ovr register.
- Reset:
  - state=IDLE; sr, ovr, counter = 0.
  - busy, done, ovr_active, scan_out = 0.
  - PIPE=1: all S* outputs = 0.
- FSM IDLE:
  - cap_start -> CAPTURE.
  - Else inj_apply -> ovr <= sr, ovr_active <= 1.
  - cap_start wins if both are asserted in the same cycle; inj_apply is then dropped.
  - inj_clear -> ovr_active <= 0. inj_clear has priority over a simultaneous inj_apply.
- FSM CAPTURE (1 cycle):
  - sr <= packed raw inputs (pre-reversal), cnt <= 0 -> SHIFT.
- FSM SHIFT, each cycle with shift_en=1:
  - sr <= {scan_in, sr[51:1]}, cnt++.
  - On the shift with cnt==51 -> DONE.
  - shift_en=0 holds state. cap_start and inj_apply are ignored.
- FSM DONE:
  - done=1 for exactly one cycle -> IDLE.
  - After a full shift, sr holds the 52 bits received on scan_in, first-in at bit 0, ready for inj_apply.
- shift_en in IDLE also shifts sr, which lets an override image be loaded without a capture. cnt is not used in IDLE.
- inj_clear in any state clears ovr_active. Override stays active during capture and shift.
- Reset asserted mid-shift: immediate return to IDLE, everything zeroed. No partial done.
- cnt is 6 bits and never wraps past 51.

Decomposition:
- Package n_term_probe_pkg:
  - PROBE_W = 52.
  - Slice offset constants: N1_LO=0, N2M_LO=4, N2E_LO=12, N4_LO=20, NN4_LO=36.
  - State enum {IDLE, CAPTURE, SHIFT, DONE}.
- One sub-module, probe_scan_ctrl: FSM, counter and shift register. The top level holds the mapping, the override mux and the PIPE register.

Test Plan:
- Reset, then N1END=4'b0001, NN4END=16'h8000, PIPE=1 -> next edge S1BEG=4'b1000, SS4BEG=16'h0001; all S* were 0 during reset.
- N4END=16'hA5C3 held, cap_start pulse, shift_en high for 52 cycles -> scan_out bits 20..35 of the stream = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB first); done pulses once on the cycle after the 52nd shift; busy=1 throughout.
- Shift in 52 bits where stream bit 4 = 1 and all others 0, then inj_apply -> S2BEG=8'h01, ovr_active=1, all other outputs 0 regardless of inputs; inj_clear -> loopback restored one edge later.
- cap_start and inj_apply in the same IDLE cycle -> CAPTURE entered, ovr_active unchanged; cap_start during SHIFT -> ignored, cnt continues.
- shift_en dropped for 10 cycles at cnt=20 -> state and sr held, done still arrives after 52 total shifts.
- Assert rst at cnt=30 -> busy=0, done never pulses, scan_out=0, state IDLE; a new capture then works normally.
